serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial add/subtract controller that sequences a single one-bit `full_adder` cell over WIDTH cycles to produce a WIDTH-bit sum or difference. It accepts an operand pair with a start/ready handshake and feeds the cell one bit per clock, LSB first. It registers carry between bits and reports result, carry-out and signed overflow with a one-cycle done pulse. It sits between the lab's operand source (bench or register file) and the existing `full_adder` datapath cell, which it instantiates internally.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only while ready=1
- sub  input  1  0 = A+B, 1 = A−B; sampled with start
- op_a  input  WIDTH  operand A; sampled with start
- op_b  input  WIDTH  operand B; sampled with start
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, result/flags valid
- result  output  WIDTH  sum/difference; holds until next accepted start
- cout  output  1  final carry-out; for sub, 1 = no borrow
- overflow  output  1  signed (two's complement) overflow

## Operation
- Datapath: one `full_adder` instance (a, b, cin → sum, cout); the controller drives a=a_sh[0], b=b_sh[0], cin=carry.
- State machine IDLE → RUN → DONE → IDLE; encoding free.
- IDLE: ready=1. On start=1 at a clock edge:
  - a_sh←op_a; b_sh←(sub ? ~op_b : op_b); carry←sub; bit count←0.
  - result, cout and overflow are cleared.
  - Next state is RUN.
- RUN, every edge:
  - result←{fa.sum, result[WIDTH-1:1]}; a_sh, b_sh shift right one bit; carry←fa.cout; count+1.
  - On the edge that processes bit WIDTH-1:
    - overflow←carry(in) XOR fa.cout
    - cout←fa.cout
    - next state is DONE.
- DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
- start and sub are ignored in RUN and DONE, with no queuing. Operand inputs may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.
- result is meaningful only when done=1, or in IDLE after a completed operation. Partial values are visible during RUN.

## Timing
- Reset (rst_n low, asynchronous, any state): state=IDLE, ready=1, busy=0, done=0, result=0, cout=0, overflow=0, carry=0, count=0. Outputs take these values immediately, without waiting for clk.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and partial results are lost.
- Latency, with start high in cycle 0 and accepted at the end of cycle 0:
  - RUN occupies cycles 1..WIDTH.
  - DONE occupies cycle WIDTH+1.
  - ready returns in cycle WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- busy = !ready at all times.
- If start is held continuously, a new operation is accepted in the first IDLE cycle, WIDTH+2 cycles after the previous acceptance.
- All outputs are registered or decoded directly from the state register, with no combinational path from inputs.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert rst_n=0 asynchronously mid-cycle → ready=1, busy=0, done=0, result=0x00, cout=0, overflow=0 before the next clk edge.
- Add timing: start, sub=0, A=0x3C, B=0x05 in cycle 0 → ready=0 in cycles 1..9; done=1 only in cycle 9 with result=0x41, cout=0, overflow=0; ready=1 in cycle 10.
- Add flags: 0xFF+0x01 → result=0x00, cout=1, overflow=0. 0x7F+0x01 → result=0x80, cout=0, overflow=1.
- Subtract: 0x05−0x07 → result=0xFE, cout=0, overflow=0. 0x80−0x01 → result=0x7F, cout=1, overflow=1. 0x10−0x10 → result=0x00, cout=1, overflow=0.
- Handshake: hold start=1 with A=0x01, B=0x02 from cycle 0; change op_a to 0xAA in cycle 3 → first done (cycle 9) gives 0x03. Second accept occurs in cycle 10, and its done (cycle 19) gives 0xAC.
- Reset abort: start 0x12+0x34, pull rst_n low in cycle 4, release in cycle 6 → no done pulse; outputs at reset values. A new start of 0x12+0x34 in cycle 7 gives done in cycle 16 with result=0x46.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract controller around a one-bit full_adder cell

// One-bit full adder cell: the whole arithmetic datapath of the controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  // Subtraction arrives pre-inverted in b_sh with carry seeded to 1, so the cell only ever adds.
  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (count == CW'(WIDTH - 1));

  // Handshake flags decode straight from the state register.
  assign ready = (state == ST_IDLE);
  assign busy  = ~ready;
  assign done  = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, run WIDTH bits, pulse DONE once.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)    state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE:               state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // Operand shifters, carry, bit counter and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      count    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh     <= op_a;
            b_sh     <= sub ? ~op_b : op_b;
            carry    <= sub;
            count    <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        ST_RUN: begin
          result <= {fa_sum, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_cout;
          count  <= count + CW'(1);
          if (last_bit) begin
            // Signed overflow: carry into the sign bit differs from carry out of it.
            overflow <= carry ^ fa_cout;
            cout     <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
